// File: rtl/addsub_pkg.sv
// Shared types and helpers for the round-robin add/sub arbiter.
// Grant picking is written for up to 8 requesters.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam int   RR_MAX = 8;

  typedef enum logic {
    ST_IDLE,
    ST_FULL
  } state_e;

  // First set valid bit at or after ptr, wrapping modulo n; one-hot.
  function automatic logic [RR_MAX-1:0] rr_pick(
    input logic [RR_MAX-1:0] valid,
    input logic [2:0]        ptr,
    input int                n
  );
    logic [RR_MAX-1:0] g;
    logic              found;
    int                idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        if (!found && valid[idx[2:0]]) begin
          g[idx[2:0]] = 1'b1;
          found       = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational W-bit ripple adder/subtractor.
// Subtract is X + ~Y + 1, so cout means "no borrow".
module addsub_core
  import addsub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ovf
);

  logic [W:0] c;
  logic       yb;

  // Ripple carry chain; ovf compares carry into and out of the MSB.
  always_comb begin
    s    = '0;
    c    = '0;
    yb   = 1'b0;
    c[0] = (sub == OP_SUB);
    for (int i = 0; i < W; i++) begin
      yb     = (sub == OP_ADD) ? y[i] : ~y[i];
      s[i]   = x[i] ^ yb ^ c[i];
      c[i+1] = (x[i] & yb) | (c[i] & (x[i] ^ yb));
    end
    cout = c[W];
    ovf  = c[W] ^ c[W-1];
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub core among N requesters.
// One registered result slot, tagged with the winning requester id.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N-1:0]   req_sub,
  input  logic [N*W-1:0] req_x,
  input  logic [N*W-1:0] req_y,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IDW-1:0] rsp_id,
  output logic [W-1:0]   rsp_s,
  output logic           rsp_cout,
  output logic           rsp_ovf
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [W-1:0]     rsp_s_q, rsp_s_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_ovf_q, rsp_ovf_d;

  logic             can_accept;
  logic [RR_MAX-1:0] grant_w;
  logic             gnt;
  logic [IDW-1:0]   gnt_idx;
  logic [W-1:0]     x_sel, y_sel;
  logic             sub_sel;
  logic [W-1:0]     core_s;
  logic             core_cout, core_ovf;

  // Grant and operand mux; no grants while reset is held.
  always_comb begin
    can_accept = rst_n & ((state_q == ST_IDLE) | rsp_ready);
    grant_w    = '0;
    if (can_accept) begin
      grant_w = rr_pick(RR_MAX'(req_valid), 3'(rr_ptr_q), N);
    end
    gnt     = |grant_w;
    gnt_idx = '0;
    x_sel   = '0;
    y_sel   = '0;
    sub_sel = OP_ADD;
    for (int i = 0; i < N; i++) begin
      if (grant_w[i]) begin
        gnt_idx = IDW'(i);
        x_sel   = req_x[i*W +: W];
        y_sel   = req_y[i*W +: W];
        sub_sel = req_sub[i];
      end
    end
  end

  assign req_ready = grant_w[N-1:0];

  addsub_core #(
    .W(W)
  ) u_core (
    .x   (x_sel),
    .y   (y_sel),
    .sub (sub_sel),
    .s   (core_s),
    .cout(core_cout),
    .ovf (core_ovf)
  );

  // Next state, pointer advance and result-slot load.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_s_d    = rsp_s_q;
    rsp_cout_d = rsp_cout_q;
    rsp_ovf_d  = rsp_ovf_q;
    if (gnt) begin
      state_d    = ST_FULL;
      rr_ptr_d   = (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + IDW'(1);
      rsp_id_d   = gnt_idx;
      rsp_s_d    = core_s;
      rsp_cout_d = core_cout;
      rsp_ovf_d  = core_ovf;
    end else if (state_q == ST_FULL && rsp_ready) begin
      state_d = ST_IDLE;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      rsp_id_q   <= '0;
      rsp_s_q    <= '0;
      rsp_cout_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_s_q    <= rsp_s_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_ovf_q  <= rsp_ovf_d;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed and scoreboarded bench for addsub_arbiter (W=8, N=4).
module tb_addsub_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int NV = 512;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_sub;
  logic [N*W-1:0] req_x;
  logic [N*W-1:0] req_y;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_s;
  logic           rsp_cout;
  logic           rsp_ovf;

  int checks = 0;
  int errors = 0;

  addsub_arbiter #(.W(W), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_sub  (req_sub),
    .req_x    (req_x),
    .req_y    (req_y),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_s    (rsp_s),
    .rsp_cout (rsp_cout),
    .rsp_ovf  (rsp_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] x;
    logic [7:0] y;
    logic       sub;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec_t;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] s;
    logic       c;
    logic       o;
  } rsp_t;

  vec_t       tv[8];
  rsp_t       sb[$];
  logic [7:0] vals[16];
  int         idx[N];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [7:0] x,
                        input logic [7:0] y, input logic sub);
    req_x[i*W +: W] = x;
    req_y[i*W +: W] = y;
    req_sub[i]      = sub;
  endtask

  // Reference built from unsigned compare and sign rules.
  function automatic rsp_t ref_op(input int id, input logic [7:0] x,
                                  input logic [7:0] y, input logic sub);
    rsp_t r;
    int   t;
    r.id = 2'(id);
    if (!sub) begin
      t   = int'(x) + int'(y);
      r.s = t[7:0];
      r.c = (t > 255);
      r.o = (x[7] == y[7]) && (r.s[7] != x[7]);
    end else begin
      r.s = x - y;
      r.c = (x >= y);
      r.o = (x[7] != y[7]) && (r.s[7] != x[7]);
    end
    return r;
  endfunction

  task automatic drive_seq(input int i, input int k);
    int p;
    p = k >> 1;
    set_op(i, vals[p >> 4], vals[(p + i) % 16], k[0]);
  endtask

  initial begin
    rsp_t exp_r;
    int   cyc;
    logic busy;

    tv[0] = '{0, 8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0};
    tv[1] = '{1, 8'h80,  8'h01,  1'b1, 8'h7F,  1'b1, 1'b1};
    tv[2] = '{2, 8'd3,   8'd5,   1'b1, 8'hFE,  1'b0, 1'b0};
    tv[3] = '{3, 8'h7F,  8'h01,  1'b0, 8'h80,  1'b0, 1'b1};
    tv[4] = '{0, 8'hFF,  8'h01,  1'b0, 8'h00,  1'b1, 1'b0};
    tv[5] = '{1, 8'h00,  8'h00,  1'b1, 8'h00,  1'b1, 1'b0};
    tv[6] = '{3, 8'h80,  8'h80,  1'b0, 8'h00,  1'b1, 1'b1};
    tv[7] = '{2, 8'h05,  8'h03,  1'b1, 8'h02,  1'b1, 1'b0};
    vals = '{8'h00, 8'h01, 8'h02, 8'h3F, 8'h40, 8'h7E, 8'h7F, 8'h80,
             8'h81, 8'hC0, 8'hFE, 8'hFF, 8'h05, 8'd100, 8'd200, 8'h55};

    rst_n     = 1'b0;
    req_valid = '0;
    req_sub   = '0;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_s", rsp_s, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_cout", rsp_cout, 0);
    chk("rst_ovf", rsp_ovf, 0);
    req_valid = 4'hF;
    #1 chk("rst_ready", req_ready, 0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: single ops, back-to-back with rsp_ready high
    rsp_ready = 1'b1;
    foreach (tv[v]) begin
      set_op(tv[v].id, tv[v].x, tv[v].y, tv[v].sub);
      req_valid = 4'(1 << tv[v].id);
      #1 chk("tbl_grant", req_ready, 32'(1 << tv[v].id));
      @(negedge clk);
      req_valid = '0;
      chk("tbl_valid", rsp_valid, 1);
      chk("tbl_rsp", {rsp_id, rsp_s, rsp_cout, rsp_ovf},
          {2'(tv[v].id), tv[v].s, tv[v].c, tv[v].o});
    end
    @(negedge clk);
    chk("tbl_idle", rsp_valid, 0);

    // Reset while holding a result
    rsp_ready = 1'b0;
    set_op(3, 8'd9, 8'd9, 1'b0);
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = '0;
    chk("pre_rst_valid", rsp_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", rsp_valid, 0);
    chk("midrst_s", rsp_s, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round robin from pointer 0
    for (int i = 0; i < N; i++) set_op(i, 8'(i * 10), 8'd1, 1'b0);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chk("rr_grant", req_ready, 32'(1 << (k % 4)));
      if (k > 0) begin
        chk("rr_id", rsp_id, 32'((k - 1) % 4));
        chk("rr_s", rsp_s, 32'(((k - 1) % 4) * 10 + 1));
      end
      @(negedge clk);
    end
    chk("rr_id_last", rsp_id, 0);
    req_valid = '0;
    @(negedge clk);
    chk("rr_idle", rsp_valid, 0);

    // Backpressure then same-cycle grant on release
    rsp_ready = 1'b0;
    set_op(1, 8'd10, 8'd20, 1'b0);
    req_valid = 4'b0010;
    #1 chk("bp_grant1", req_ready, 4'b0010);
    @(negedge clk);
    set_op(2, 8'd50, 8'd8, 1'b1);
    req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", req_ready, 0);
      chk("bp_hold", {rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_ovf},
          {1'b1, 2'd1, 8'd30, 1'b0, 1'b0});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 chk("bp_grant2", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    chk("bp_new", {rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_ovf},
        {1'b1, 2'd2, 8'd42, 1'b1, 1'b0});
    @(negedge clk);
    chk("bp_idle", rsp_valid, 0);

    // Sweep with all requesters active and random rsp_ready
    for (int i = 0; i < N; i++) idx[i] = 0;
    cyc  = 0;
    busy = 1'b1;
    while (busy && cyc < 20000) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (idx[i] < NV) begin
          req_valid[i] = 1'b1;
          drive_seq(i, idx[i]);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      #1;
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("sweep_unexpected", 1, 0);
        end else begin
          exp_r = sb.pop_front();
          chk("sweep_rsp", {rsp_id, rsp_s, rsp_cout, rsp_ovf}, exp_r);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back(ref_op(i, req_x[i*W +: W], req_y[i*W +: W],
                              req_sub[i]));
          idx[i]++;
        end
      end
      @(negedge clk);
      cyc++;
      busy = (sb.size() != 0) || rsp_valid;
      for (int i = 0; i < N; i++) if (idx[i] < NV) busy = 1'b1;
    end
    chk("sweep_done", busy, 0);
    req_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
